// File: rtl/key_bank_decoder_if.sv
// ---------------------------------------------------------------------------
// key_bank_decoder_if
// Scan-code event bus from the keyboard front end to the key bank decoder.
//   keyCode : 9-bit scan code qualified by the strobes below
//   make    : one-cycle strobe, keyCode is being pressed
//   brakee  : one-cycle strobe, keyCode is being released
// Modports: master drives the bus (front end / testbench), slave receives it.
// ---------------------------------------------------------------------------
interface key_bank_decoder_if;
  logic [8:0] keyCode;
  logic       make;
  logic       brakee;

  modport master (output keyCode, output make, output brakee);
  modport slave  (input  keyCode, input  make, input  brakee);
endinterface

// File: rtl/key_bank_decoder.sv
// ---------------------------------------------------------------------------
// key_bank_decoder
// Decodes make/break scan-code events into NUM_KEYS independent key channels,
// each with held state, edge pulses, a press toggle and a typematic
// auto-repeat pulse train (first repeat REPEAT_DELAY cycles after the press,
// then every REPEAT_PERIOD cycles while held).
// Ports:
//   clk                 : clock, all state on the rising edge
//   reset               : asynchronous active-high reset
//   scan                : scan-code bus (keyCode, make, brakee), slave side
//   keyValues           : scan code of channel i in bits [9i+8:9i]
//   repeatEnable        : global auto-repeat enable (gates repeats only)
//   keyIsPressed        : per-channel held state
//   keyRisingEdgePulse  : one cycle high on press
//   keyFallingEdgePulse : one cycle high on release
//   keyToggle           : inverts on each press
//   keyRepeatPulse      : press pulse plus auto-repeat pulses
//   anyKeyPressed       : OR of keyIsPressed
// ---------------------------------------------------------------------------
module key_bank_decoder #(
  parameter int NUM_KEYS      = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  key_bank_decoder_if.slave       scan,
  input  logic [9*NUM_KEYS-1:0]   keyValues,
  input  logic                    repeatEnable,
  output logic [NUM_KEYS-1:0]     keyIsPressed,
  output logic [NUM_KEYS-1:0]     keyRisingEdgePulse,
  output logic [NUM_KEYS-1:0]     keyFallingEdgePulse,
  output logic [NUM_KEYS-1:0]     keyToggle,
  output logic [NUM_KEYS-1:0]     keyRepeatPulse,
  output logic                    anyKeyPressed
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

  logic [NUM_KEYS-1:0] match;
  logic [NUM_KEYS-1:0] keyIsPressed_d;
  logic [NUM_KEYS-1:0] held;
  rep_state_e          state [NUM_KEYS];
  logic [CW-1:0]       cnt   [NUM_KEYS];

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i] = (scan.keyCode == keyValues[9*i +: 9]);
    end
  end

  // Held state; a simultaneous make and break resolves as a release.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keyIsPressed   <= '0;
      keyIsPressed_d <= '0;
      keyToggle      <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (match[i] && scan.brakee) begin
          keyIsPressed[i] <= 1'b0;
        end else if (match[i] && scan.make) begin
          keyIsPressed[i] <= 1'b1;
        end
      end
      keyIsPressed_d <= keyIsPressed;
      keyToggle      <= keyToggle ^ keyRisingEdgePulse;
    end
  end

  assign keyRisingEdgePulse  = keyIsPressed & ~keyIsPressed_d;
  assign keyFallingEdgePulse = ~keyIsPressed & keyIsPressed_d;
  assign anyKeyPressed       = |keyIsPressed;

  // The repeat timer starts one cycle after the press pulse (once both the
  // live and delayed held bits are set), so that DELAY reaching
  // REPEAT_DELAY-1 lands exactly REPEAT_DELAY cycles after the press pulse.
  // A release still drops the FSM to IDLE on the very next edge.
  assign held = keyIsPressed & keyIsPressed_d;

  // Per-channel typematic FSMs. The state/counter arrays are a handful of
  // flops per channel, so they are cleared by reset like any other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (!held[i]) begin
          state[i] <= IDLE;
          cnt[i]   <= '0;
        end else begin
          unique case (state[i])
            IDLE: begin
              state[i] <= DELAY;
              cnt[i]   <= CW'(1);
            end
            DELAY: begin
              if (cnt[i] == DELAY_LAST) begin
                state[i] <= REPEAT;
                cnt[i]   <= '0;
              end else begin
                cnt[i] <= cnt[i] + 1'b1;
              end
            end
            REPEAT: begin
              cnt[i] <= (cnt[i] == PERIOD_LAST) ? '0 : cnt[i] + 1'b1;
            end
            default: begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Repeat pulses decode the current state, so a release coinciding with a
  // due repeat still emits it. repeatEnable gates the pulse, not the timer.
  always_comb begin
    keyRepeatPulse = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      keyRepeatPulse[i] = keyRisingEdgePulse[i] |
                          (repeatEnable &
                           (((state[i] == DELAY)  && (cnt[i] == DELAY_LAST)) ||
                            ((state[i] == REPEAT) && (cnt[i] == PERIOD_LAST))));
    end
  end

endmodule
